// File: rtl/uart_cmd_engine.sv
// UART command engine: parses byte-serial commands from a UART receiver and
// performs single/burst SRAM accesses, replying through the UART transmitter.
module uart_cmd_engine #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int CNT_W      = 16,
  parameter int RX_TIMEOUT = 5000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_send,
  input  logic              tx_busy,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic [7:0]        drop_count
);
  localparam int HW = ADDR_W + CNT_W;
  localparam int TW = $clog2(RX_TIMEOUT + 1);
  localparam logic [7:0] AB = 8'(ADDR_W / 8);
  localparam logic [7:0] CB = 8'(CNT_W / 8);
  localparam logic [7:0] DB = 8'(DATA_W / 8);
  localparam logic [TW-1:0] TLIM = TW'(RX_TIMEOUT - 1);
  localparam logic [7:0] OP_PING = 8'h80, OP_WR = 8'h02, OP_RD = 8'h03;
  localparam logic [7:0] OP_BWR  = 8'h04, OP_BRD = 8'h05;
  localparam logic [7:0] R_ACK = 8'h01, R_CSUM = 8'hFE, R_TOUT = 8'hFD;
  localparam logic [7:0] R_OVR = 8'hFC, R_BAD = 8'hFF;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_WDATA, S_MEM, S_TXDATA, S_TXCSUM, S_RCSUM, S_REPLY, S_GAP
  } state_e;

  state_e            state_q, state_d, ret_q, ret_d;
  logic [7:0]        op_q, op_d;
  logic [HW-1:0]     hdr_q, hdr_d;
  logic [7:0]        bcnt_q, bcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        reply_q, reply_d;
  logic              hold_q, hold_d;
  logic              req_q, req_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        txd_q, txd_d;
  logic              send_q, send_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [7:0]        drop_q, drop_d;
  logic              busy_q;

  logic [HW-1:0]     hdr_sh_s;
  logic [DATA_W-1:0] word_sh_s;
  logic              is_burst_s;
  logic [7:0]        hdr_need_s;
  logic              timed_s;
  logic              timeout_s;
  logic              drop_st_s;

  assign hdr_sh_s   = (hdr_q << 8) | HW'(rx_data);
  assign word_sh_s  = (word_q << 8) | DATA_W'(rx_data);
  assign is_burst_s = (op_q == OP_BWR) || (op_q == OP_BRD);
  assign hdr_need_s = is_burst_s ? (AB + CB) : AB;
  assign timed_s    = (state_q == S_HDR) || (state_q == S_WDATA) || (state_q == S_RCSUM);
  assign timeout_s  = timed_s && !rx_valid && (tmr_q == TLIM);
  assign drop_st_s  = state_q inside {S_MEM, S_TXDATA, S_TXCSUM, S_REPLY, S_GAP};

  // Next-state, datapath and memory/transmit handshake logic.
  always_comb begin
    state_d = state_q;  ret_d   = ret_q;   op_d    = op_q;    hdr_d   = hdr_q;
    bcnt_d  = bcnt_q;   addr_d  = addr_q;  cnt_d   = cnt_q;   word_d  = word_q;
    csum_d  = csum_q;   reply_d = reply_q; wr_d    = wr_q;    maddr_d = maddr_q;
    wdata_d = wdata_q;  txd_d   = txd_q;   send_d  = 1'b0;
    // An acknowledged request drops next cycle unless a new one is issued below.
    if (req_q && mem_ack) begin
      req_d  = 1'b0;
      hold_d = 1'b0;
    end else begin
      req_d  = req_q;
      hold_d = hold_q;
    end
    if (rx_valid && drop_st_s && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end
    if (timed_s && !rx_valid) begin
      tmr_d = tmr_q + TW'(1);
    end else begin
      tmr_d = '0;
    end
    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          op_d   = rx_data;
          bcnt_d = 8'd0;
          csum_d = 8'd0;
          hdr_d  = '0;
          case (rx_data)
            OP_PING: begin reply_d = R_ACK; state_d = S_REPLY; end
            OP_WR, OP_RD, OP_BWR, OP_BRD: state_d = S_HDR;
            default: begin reply_d = R_BAD; state_d = S_REPLY; end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR: begin
        if (timeout_s) begin
          reply_d = R_TOUT;
          state_d = S_REPLY;
        end else if (rx_valid) begin
          hdr_d  = hdr_sh_s;
          bcnt_d = bcnt_q + 8'd1;
          if (bcnt_q == hdr_need_s - 8'd1) begin
            bcnt_d = 8'd0;
            if (is_burst_s) begin
              addr_d = hdr_sh_s[HW-1 -: ADDR_W];
              cnt_d  = hdr_sh_s[CNT_W-1:0];
            end else begin
              addr_d = hdr_sh_s[ADDR_W-1:0];
              cnt_d  = '0;
            end
            if ((op_q == OP_WR) || (op_q == OP_BWR)) begin
              state_d = S_WDATA;
            end else begin
              req_d   = 1'b1;
              wr_d    = 1'b0;
              maddr_d = addr_d;
              state_d = S_MEM;
            end
          end else begin
            state_d = S_HDR;
          end
        end else begin
          state_d = S_HDR;
        end
      end
      S_WDATA: begin
        if (timeout_s) begin
          reply_d = R_TOUT;
          state_d = S_REPLY;
        end else if (rx_valid) begin
          word_d = word_sh_s;
          csum_d = csum_q ^ rx_data;
          bcnt_d = bcnt_q + 8'd1;
          if (bcnt_q == DB - 8'd1) begin
            bcnt_d = 8'd0;
            if (op_q == OP_WR) begin
              req_d = 1'b1; wr_d = 1'b1; maddr_d = addr_q; wdata_d = word_sh_s;
              state_d = S_MEM;
            end else if (hold_q && !mem_ack) begin
              reply_d = R_OVR;
              state_d = S_REPLY;
            end else begin
              req_d = 1'b1; wr_d = 1'b1; maddr_d = addr_q; wdata_d = word_sh_s;
              hold_d = 1'b1;
              addr_d = addr_q + ADDR_W'(1);
              if (cnt_q == '0) begin
                state_d = S_RCSUM;
              end else begin
                cnt_d = cnt_q - CNT_W'(1);
              end
            end
          end else begin
            state_d = S_WDATA;
          end
        end else begin
          state_d = S_WDATA;
        end
      end
      S_RCSUM: begin
        if (timeout_s) begin
          reply_d = R_TOUT;
          state_d = S_REPLY;
        end else if (rx_valid) begin
          reply_d = (rx_data == csum_q) ? R_ACK : R_CSUM;
          state_d = S_REPLY;
        end else begin
          state_d = S_RCSUM;
        end
      end
      S_MEM: begin
        if (req_q && mem_ack) begin
          if (wr_q) begin
            reply_d = R_ACK;
            state_d = S_REPLY;
          end else begin
            word_d  = mem_rdata;
            bcnt_d  = 8'd0;
            state_d = S_TXDATA;
          end
        end else begin
          state_d = S_MEM;
        end
      end
      S_TXDATA: begin
        if (!tx_busy) begin
          txd_d   = word_q[DATA_W-1 -: 8];
          send_d  = 1'b1;
          csum_d  = csum_q ^ word_q[DATA_W-1 -: 8];
          word_d  = word_q << 8;
          bcnt_d  = bcnt_q + 8'd1;
          state_d = S_GAP;
          if (bcnt_q == DB - 8'd1) begin
            bcnt_d = 8'd0;
            if (op_q == OP_RD) begin
              reply_d = R_ACK;
              ret_d   = S_REPLY;
            end else if (cnt_q == '0) begin
              ret_d = S_TXCSUM;
            end else begin
              cnt_d  = cnt_q - CNT_W'(1);
              addr_d = addr_q + ADDR_W'(1);
              ret_d  = S_MEM;
            end
          end else begin
            ret_d = S_TXDATA;
          end
        end else begin
          state_d = S_TXDATA;
        end
      end
      S_TXCSUM: begin
        if (!tx_busy) begin
          txd_d   = csum_q;
          send_d  = 1'b1;
          reply_d = R_ACK;
          ret_d   = S_REPLY;
          state_d = S_GAP;
        end else begin
          state_d = S_TXCSUM;
        end
      end
      S_REPLY: begin
        // Outstanding writes must complete before the single reply byte goes out.
        if (!tx_busy && !req_q) begin
          txd_d   = reply_q;
          send_d  = 1'b1;
          ret_d   = S_IDLE;
          state_d = S_GAP;
        end else begin
          state_d = S_REPLY;
        end
      end
      S_GAP: begin
        state_d = ret_q;
        if (ret_q == S_MEM) begin
          req_d   = 1'b1;
          wr_d    = 1'b0;
          maddr_d = addr_q;
        end else begin
          req_d = req_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  ret_q   <= S_IDLE;  op_q    <= 8'd0;  hdr_q   <= '0;
      bcnt_q  <= 8'd0;    addr_q  <= '0;      cnt_q   <= '0;    word_q  <= '0;
      csum_q  <= 8'd0;    reply_q <= 8'd0;    hold_q  <= 1'b0;  req_q   <= 1'b0;
      wr_q    <= 1'b0;    maddr_q <= '0;      wdata_q <= '0;    txd_q   <= 8'd0;
      send_q  <= 1'b0;    tmr_q   <= '0;      drop_q  <= 8'd0;  busy_q  <= 1'b0;
    end else begin
      state_q <= state_d; ret_q   <= ret_d;   op_q    <= op_d;   hdr_q   <= hdr_d;
      bcnt_q  <= bcnt_d;  addr_q  <= addr_d;  cnt_q   <= cnt_d;  word_q  <= word_d;
      csum_q  <= csum_d;  reply_q <= reply_d; hold_q  <= hold_d; req_q   <= req_d;
      wr_q    <= wr_d;    maddr_q <= maddr_d; wdata_q <= wdata_d; txd_q  <= txd_d;
      send_q  <= send_d;  tmr_q   <= tmr_d;   drop_q  <= drop_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign tx_data    = txd_q;
  assign tx_send    = send_q;
  assign mem_req    = req_q;
  assign mem_wr     = wr_q;
  assign mem_addr   = maddr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = busy_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_uart_cmd_engine.sv
// Directed self-checking bench for uart_cmd_engine with UART transmitter and
// SRAM responder models; short receive timeout for quick simulation.
`timescale 1ns/1ps
module tb_uart_cmd_engine;
  localparam int TOUT  = 40;
  localparam int TXLEN = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_busy = 1'b0;
  logic        mem_req, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic [7:0]  drop_count;

  int errors = 0;
  int checks = 0;
  int tx_viol = 0;
  logic ack_hold = 1'b0;
  logic [7:0]  tx_q[$];
  logic [15:0] ra_q[$];
  logic [15:0] rd_q[$];
  logic        rw_q[$];
  logic [15:0] mem [0:65535];

  uart_cmd_engine #(.DATA_W(16), .ADDR_W(16), .CNT_W(16), .RX_TIMEOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // UART transmitter: captures sent bytes, goes busy the cycle after a send.
  initial begin : tx_model
    int left;
    logic start;
    left = 0;
    start = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (start) begin
        tx_busy = 1'b1; left = TXLEN; start = 1'b0;
      end else if (left > 0) begin
        left--;
        if (left == 0) tx_busy = 1'b0;
      end
      if (tx_send === 1'b1) begin
        if (tx_busy !== 1'b0) tx_viol++;
        tx_q.push_back(tx_data);
        start = 1'b1;
      end
    end
  end

  // SRAM responder: acknowledges one cycle after seeing a request unless held.
  initial begin : mem_model
    forever begin
      @(posedge clk); #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req === 1'b1 && !ack_hold) begin
        ra_q.push_back(mem_addr);
        rw_q.push_back(mem_wr);
        if (mem_wr) begin
          mem[mem_addr] = mem_wdata;
          rd_q.push_back(mem_wdata);
        end else begin
          mem_rdata = mem[mem_addr];
          rd_q.push_back(mem[mem_addr]);
        end
        mem_ack = 1'b1;
      end
    end
  end

  function automatic logic [7:0] txb(input int i);
    return (i < tx_q.size()) ? tx_q[i] : 8'hxx;
  endfunction
  function automatic logic [15:0] rab(input int i);
    return (i < ra_q.size()) ? ra_q[i] : 16'hxxxx;
  endfunction
  function automatic logic [15:0] rdb(input int i);
    return (i < rd_q.size()) ? rd_q[i] : 16'hxxxx;
  endfunction
  function automatic logic rwb(input int i);
    return (i < rw_q.size()) ? rw_q[i] : 1'bx;
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask
  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1; tick(1); rx_valid = 1'b0; tick(2);
  endtask
  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin tick(1); n++; end
    ok = (busy === 1'b0);
    tick(3);
  endtask
  task automatic clear_logs();
    tx_q.delete(); ra_q.delete(); rd_q.delete(); rw_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++; if (tx_send !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx: send=%b data=%h, required 0 00", tx_send, tx_data); end
    checks++; if ({mem_req, mem_wr, mem_addr, mem_wdata} !== 34'd0) begin errors++; $display("FAIL reset_mem: req=%b wr=%b addr=%h wdata=%h, required all 0", mem_req, mem_wr, mem_addr, mem_wdata); end
    checks++; if (busy !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL reset_status: busy=%b drops=%0d, required 0 0", busy, drop_count); end
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_ping();
    bit ok;
    clear_logs();
    rx_data = 8'h80; rx_valid = 1'b1; tick(1); rx_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ping_busy: busy=%b after rx, required 1", busy); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ping_idle: busy stuck, required idle"); end
    checks++; if (tx_q.size() != 1 || txb(0) !== 8'h01) begin errors++; $display("FAIL ping_tx: %0d bytes first=%h, required 1 byte 01", tx_q.size(), txb(0)); end
    checks++; if (ra_q.size() != 0) begin errors++; $display("FAIL ping_mem: %0d requests, required 0", ra_q.size()); end
  endtask

  task automatic test_write_read();
    bit ok;
    logic [7:0] exp[$];
    clear_logs();
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34); send_byte(8'hBE); send_byte(8'hEF);
    wait_idle(ok);
    checks++; if (ra_q.size() != 1 || rab(0) !== 16'h1234 || rwb(0) !== 1'b1 || rdb(0) !== 16'hBEEF) begin errors++; $display("FAIL write_mem: n=%0d addr=%h wr=%b data=%h, required 1 1234 1 BEEF", ra_q.size(), rab(0), rwb(0), rdb(0)); end
    checks++; if (!ok || tx_q.size() != 1 || txb(0) !== 8'h01) begin errors++; $display("FAIL write_tx: n=%0d byte=%h, required 1 byte 01", tx_q.size(), txb(0)); end
    clear_logs();
    send_byte(8'h03); send_byte(8'h12); send_byte(8'h34);
    wait_idle(ok);
    checks++; if (ra_q.size() != 1 || rab(0) !== 16'h1234 || rwb(0) !== 1'b0) begin errors++; $display("FAIL read_mem: n=%0d addr=%h wr=%b, required 1 1234 0", ra_q.size(), rab(0), rwb(0)); end
    exp = '{8'hBE, 8'hEF, 8'h01};
    checks++; if (!ok || tx_q.size() != 3) begin errors++; $display("FAIL read_txlen: got %0d bytes, required 3", tx_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (txb(i) !== exp[i]) begin errors++; $display("FAIL read_tx[%0d]: got %h, required %h", i, txb(i), exp[i]); end
    end
  endtask

  task automatic test_burst_read_wrap();
    bit ok;
    logic [7:0] exp[$];
    clear_logs();
    mem[16'hFFFF] = 16'h1122;
    mem[16'h0000] = 16'h3344;
    send_byte(8'h05); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h00); send_byte(8'h01);
    wait_idle(ok);
    checks++; if (ra_q.size() != 2 || rab(0) !== 16'hFFFF || rab(1) !== 16'h0000 || rwb(0) !== 1'b0 || rwb(1) !== 1'b0) begin errors++; $display("FAIL bread_addr: n=%0d a0=%h a1=%h, required 2 reads FFFF 0000", ra_q.size(), rab(0), rab(1)); end
    exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 8'h01};
    checks++; if (!ok || tx_q.size() != 6) begin errors++; $display("FAIL bread_txlen: got %0d bytes, required 6", tx_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (txb(i) !== exp[i]) begin errors++; $display("FAIL bread_tx[%0d]: got %h, required %h", i, txb(i), exp[i]); end
    end
  endtask

  task automatic test_burst_write();
    bit ok;
    logic [7:0] hdr[$];
    hdr = '{8'h04, 8'h00, 8'h10, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int pass = 0; pass < 2; pass++) begin
      clear_logs();
      foreach (hdr[i]) send_byte(hdr[i]);
      send_byte(pass == 0 ? 8'h00 : 8'h55);
      wait_idle(ok);
      checks++; if (ra_q.size() != 2 || rab(0) !== 16'h0010 || rab(1) !== 16'h0011 || rdb(0) !== 16'hAABB || rdb(1) !== 16'hCCDD || rwb(0) !== 1'b1 || rwb(1) !== 1'b1) begin errors++; $display("FAIL bwrite_mem%0d: n=%0d %h=%h %h=%h, required 0010=AABB 0011=CCDD", pass, ra_q.size(), rab(0), rdb(0), rab(1), rdb(1)); end
      checks++; if (!ok || tx_q.size() != 1 || txb(0) !== (pass == 0 ? 8'h01 : 8'hFE)) begin errors++; $display("FAIL bwrite_tx%0d: n=%0d byte=%h, required 1 byte %h", pass, tx_q.size(), txb(0), (pass == 0 ? 8'h01 : 8'hFE)); end
    end
    clear_logs();
    ack_hold = 1'b1;
    hdr = '{8'h04, 8'h00, 8'h20, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    foreach (hdr[i]) send_byte(hdr[i]);
    tick(4);
    ack_hold = 1'b0;
    wait_idle(ok);
    checks++; if (!ok || tx_q.size() != 1 || txb(0) !== 8'hFC) begin errors++; $display("FAIL bwrite_ovr_tx: n=%0d byte=%h, required 1 byte FC", tx_q.size(), txb(0)); end
    checks++; if (ra_q.size() != 1 || rab(0) !== 16'h0020 || rdb(0) !== 16'h1122) begin errors++; $display("FAIL bwrite_ovr_mem: n=%0d %h=%h, required 1 write 0020=1122", ra_q.size(), rab(0), rdb(0)); end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_logs();
    send_byte(8'h02); send_byte(8'h12);
    tick(TOUT - 10);
    checks++; if (tx_q.size() != 0 || busy !== 1'b1) begin errors++; $display("FAIL tout_early: n=%0d busy=%b, required 0 bytes busy 1", tx_q.size(), busy); end
    wait_idle(ok);
    checks++; if (!ok || tx_q.size() != 1 || txb(0) !== 8'hFD) begin errors++; $display("FAIL tout_tx: n=%0d byte=%h, required 1 byte FD", tx_q.size(), txb(0)); end
    checks++; if (ra_q.size() != 0) begin errors++; $display("FAIL tout_mem: %0d requests, required 0", ra_q.size()); end
    clear_logs();
    send_byte(8'h80);
    wait_idle(ok);
    checks++; if (!ok || tx_q.size() != 1 || txb(0) !== 8'h01) begin errors++; $display("FAIL tout_ping: n=%0d byte=%h, required 1 byte 01", tx_q.size(), txb(0)); end
  endtask

  task automatic test_unknown();
    bit ok;
    clear_logs();
    send_byte(8'h42);
    wait_idle(ok);
    checks++; if (!ok || tx_q.size() != 1 || txb(0) !== 8'hFF) begin errors++; $display("FAIL unk_tx: n=%0d byte=%h, required 1 byte FF", tx_q.size(), txb(0)); end
    clear_logs();
    send_byte(8'h80);
    wait_idle(ok);
    checks++; if (!ok || tx_q.size() != 1 || txb(0) !== 8'h01) begin errors++; $display("FAIL unk_next: n=%0d byte=%h, required 1 byte 01", tx_q.size(), txb(0)); end
  endtask

  task automatic test_drops();
    bit ok;
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL drop_start: got %0d, required 0", drop_count); end
    clear_logs();
    send_byte(8'h03); send_byte(8'h12); send_byte(8'h34);
    for (int i = 0; i < 3; i++) send_byte(8'h80);
    wait_idle(ok);
    checks++; if (drop_count !== 8'd3) begin errors++; $display("FAIL drop_three: got %0d, required 3", drop_count); end
    checks++; if (!ok || tx_q.size() != 3 || txb(0) !== 8'hBE || txb(1) !== 8'hEF || txb(2) !== 8'h01) begin errors++; $display("FAIL drop_reply: n=%0d %h %h %h, required BE EF 01", tx_q.size(), txb(0), txb(1), txb(2)); end
    clear_logs();
    ack_hold = 1'b1;
    send_byte(8'h03); send_byte(8'h12); send_byte(8'h34);
    for (int i = 0; i < 251; i++) begin rx_valid = 1'b1; tick(1); rx_valid = 1'b0; tick(1); end
    checks++; if (drop_count !== 8'd254) begin errors++; $display("FAIL drop_254: got %0d, required 254", drop_count); end
    rx_valid = 1'b1; tick(1); rx_valid = 1'b0; tick(1);
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_255: got %0d, required 255", drop_count); end
    for (int i = 0; i < 45; i++) begin rx_valid = 1'b1; tick(1); rx_valid = 1'b0; tick(1); end
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_sat: got %0d, required 255", drop_count); end
    ack_hold = 1'b0;
    wait_idle(ok);
    checks++; if (!ok || tx_q.size() != 3 || txb(0) !== 8'hBE || txb(1) !== 8'hEF || txb(2) !== 8'h01) begin errors++; $display("FAIL drop_sat_reply: n=%0d %h %h %h, required BE EF 01", tx_q.size(), txb(0), txb(1), txb(2)); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    logic [7:0] hdr[$];
    clear_logs();
    ack_hold = 1'b1;
    hdr = '{8'h04, 8'h00, 8'h40, 8'h00, 8'h01, 8'hAA, 8'hBB};
    foreach (hdr[i]) send_byte(hdr[i]);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmid_req_before: got %b, required 1", mem_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL rmid_clear: req=%b busy=%b drops=%0d, required 0 0 0", mem_req, busy, drop_count); end
    tick(2);
    rst_n = 1'b1;
    ack_hold = 1'b0;
    tick(3);
    rx_data = 8'h80; rx_valid = 1'b1; tick(1); rx_valid = 1'b0;
    n = 0;
    while (tx_send !== 1'b1 && n < 20) begin tick(1); n++; end
    checks++; if (tx_send !== 1'b1) begin errors++; $display("FAIL rmid_send_seen: tx_send=%b, required 1 within 20 cycles", tx_send); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx_send !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL rmid_tx_clear: send=%b data=%h, required 0 00", tx_send, tx_data); end
    tick(2);
    rst_n = 1'b1;
    tick(TXLEN + 4);
    clear_logs();
    tick(10);
    checks++; if (tx_q.size() != 0 || ra_q.size() != 0) begin errors++; $display("FAIL rmid_quiet: tx=%0d mem=%0d, required 0 0", tx_q.size(), ra_q.size()); end
    send_byte(8'h80);
    wait_idle(ok);
    checks++; if (!ok || tx_q.size() != 1 || txb(0) !== 8'h01) begin errors++; $display("FAIL rmid_ping: n=%0d byte=%h, required 1 byte 01", tx_q.size(), txb(0)); end
  endtask

  initial begin
    test_reset();
    test_ping();
    test_write_read();
    test_burst_read_wrap();
    test_burst_write();
    test_timeout();
    test_unknown();
    test_drops();
    test_reset_mid();
    checks++; if (tx_viol != 0) begin errors++; $display("FAIL tx_while_busy: %0d sends with tx_busy high, required 0", tx_viol); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_cmd_engine.md
Name: uart_cmd_engine

Overview:
- Parametrised successor of the board's UART control command processor; sits between a byte-level UART RX/TX pair and the external SRAM arbiter port.
- Generalised data/address widths; adds burst read/write with XOR checksum, an inter-byte receive timeout, a word-overrun check and a dropped-byte counter.
- Implemented as one FSM with byte-serial header/payload shifters and a one-word write holding buffer.

Parameters:
- DATA_W, 16, memory word width; multiple of 8; DB = DATA_W/8 bytes per word.
- ADDR_W, 16, memory address width; multiple of 8; AB = ADDR_W/8 address bytes.
- CNT_W, 16, burst count field width; multiple of 8; CB = CNT_W/8 count bytes.
- RX_TIMEOUT, 5000000, idle-cycle limit between bytes within one command (100 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset; asynchronous, active-low.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid.
- tx_data  out  8  byte to transmit.
- tx_send  out  1  one-cycle transmit strobe.
- tx_busy  in  1  transmitter busy.
- mem_req  out  1  memory request; held until mem_ack.
- mem_wr  out  1  1 = write, 0 = read; stable while mem_req.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data; sampled on mem_ack.
- mem_ack  in  1  one-cycle completion strobe.
- busy  out  1  high whenever the FSM is not in IDLE.
- drop_count  out  8  saturating count of dropped rx bytes.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE.
- Multi-byte fields (addr, count, data) are sent MSB byte first. Burst length is count+1 words; count = 0 means one word.
- Addresses increment modulo 2^ADDR_W; a burst crossing the top wraps to 0.
- Command opcodes:
  - 0x80 PING: reply ACK 0x01.
  - 0x02 WRITE: addr, data; perform one write, ACK after mem_ack.
  - 0x03 READ: addr; perform one read, return DB data bytes, then ACK.
  - 0x04 BURST_WRITE: addr, count, (count+1) words, then checksum byte. Reply ACK, or 0xFE if the checksum mismatches; words are already committed either way.
  - 0x05 BURST_READ: addr, count; return (count+1) words, then checksum byte, then ACK.
  - Any other opcode: reply 0xFF, return to IDLE; following bytes are parsed as new commands.
- Checksum: XOR of every data byte in the burst.
- FSM states: IDLE, HDR (addr/count bytes), WDATA (word bytes), MEM (req/ack), TXDATA, TXCSUM, RCSUM, REPLY, GAP.
- Memory handshake: assert mem_req with mem_wr/mem_addr/mem_wdata stable. mem_ack may arrive the same cycle as mem_req or later; mem_req deasserts the cycle after mem_ack. Back-to-back requests are allowed.
- TX rules:
  - tx_send pulses only in a cycle where tx_busy = 0.
  - After every tx_send, the FSM spends one GAP cycle before sampling tx_busy again.
  - tx_data is stable from the tx_send cycle until the next send.
- BURST_WRITE overlap: a completed word moves to the holding buffer and its write issues while the next word is still being received.
  - If another word completes while the held write is unacknowledged: abort, reply 0xFC.
  - Holding buffer empties on mem_ack.
- Timeout: a counter reloads on each accepted byte and runs only in HDR/WDATA/RCSUM. After RX_TIMEOUT cycles without a byte: reply 0xFD, go to IDLE; partial data is discarded.
- Dropped bytes: an rx_valid in TXDATA/TXCSUM/REPLY/GAP, or in MEM for single commands, is discarded. drop_count increments and saturates at 255.
- Reply arbitration: when an error and completion coincide, the error code wins. Exactly one reply byte is sent per command.
- Reset assertion at any point: outputs clear immediately, including mem_req and tx_send mid-operation; no reply is sent.

Test Plan:
- PING: rx 0x80 -> tx 0x01 exactly once; busy high from the cycle after rx_valid until the GAP after the reply.
- WRITE then READ: rx 02 12 34 BE EF -> mem write addr 0x1234 data 0xBEEF, tx 01. Then rx 03 12 34 with mem_rdata 0xBEEF -> tx BE, EF, 01.
- BURST_READ with wrap: rx 05 FF FF 00 01, memory [FFFF]=0x1122, [0000]=0x3344 -> addresses FFFF then 0000; tx 11 22 33 44, checksum 0x44, then 01.
- BURST_WRITE:
  - rx 04 00 10 00 01 AA BB CC DD 00 -> writes [0010]=AABB, [0011]=CCDD; checksum 0x00 matches; tx 01.
  - Repeat with checksum 0x55 -> tx FE.
  - Hold mem_ack low through the second word -> tx FC.
- Timeout: rx 02 12 then silence for RX_TIMEOUT cycles -> tx FD, no mem_req. Next rx 80 -> tx 01.
- Unknown opcode and drops: rx 0x42 -> tx FF. Bytes injected during a READ reply increment drop_count; 300 such bytes leave drop_count at 255. rst_n low mid-burst -> mem_req and tx_send low immediately.
